// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and helpers
//
// Purpose: enums shared by the UART receiver (and a future transmitter).
//   parity_mode_t : line parity setting (NONE, EVEN, ODD)
//   rx_state_t    : receiver FSM states
//   decode_parity : maps the raw 2-bit mode field; 2'b11 folds to NONE
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    EVEN = 2'b01,
    ODD  = 2'b10
  } parity_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  function automatic parity_mode_t decode_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   return EVEN;
      2'b10:   return ODD;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - reloadable oversample tick divider
//
// Purpose: emits one tick every div_i+1 clk cycles. A reload restarts the
// period so the caller can phase-align ticks to an external event.
// Ports:
//   clk      in   clock, rising edge
//   rst_i    in   synchronous active-high reset
//   div_i    in   16-bit divide value (period = div_i+1)
//   reload_i in   restart the period this cycle (suppresses the tick)
//   tick_o   out  single-cycle tick
module uart_baud_tick (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [15:0] div_i,
  input  logic        reload_i,
  output logic        tick_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign tick_o = !reload_i && (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (reload_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable oversampling UART receiver
//
// Purpose: receives 8N1-style frames with configurable data width, parity
// and stop bits, presenting each word through a valid/ready output register.
// Ports:
//   clk           in   clock, rising edge
//   rst_i         in   synchronous active-high reset
//   clk_div_i     in   oversample tick every clk_div_i+1 cycles
//   parity_mode_i in   00 none, 01 even, 10 odd, 11 none
//   stop2_i       in   0 one stop bit, 1 two stop bits
//   rx_i          in   asynchronous serial line, idle high
//   rx_data_o     out  received word, first line bit in LSB
//   rx_valid_o    out  word and error flags valid
//   rx_ready_i    in   consumer accepts the word
//   parity_err_o  out  parity mismatch (qualified by rx_valid_o)
//   frame_err_o   out  a stop bit sampled low (qualified by rx_valid_o)
//   overrun_o     out  one-cycle pulse when a completed frame was dropped
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OS     = 16
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic [15:0]       clk_div_i,
  input  logic [1:0]        parity_mode_i,
  input  logic              stop2_i,
  input  logic              rx_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              overrun_o
);

  localparam int TW = $clog2(OS);
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [TW-1:0] HALF_TICK = TW'(OS / 2 - 1);
  localparam logic [TW-1:0] FULL_TICK = TW'(OS - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);

  // Line synchronizer plus one extra stage for falling-edge detection
  logic sync1_q, sync2_q, prev_q;
  logic rx_s;
  logic start_edge;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_s       = sync2_q;
  assign start_edge = prev_q & ~sync2_q;

  // Frame configuration, captured at the start edge
  logic [15:0]  div_q;
  parity_mode_t par_mode_q;
  logic         stop2_q;

  rx_state_t         state_q;
  logic [TW-1:0]     tick_cnt_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;
  logic              perr_acc_q;
  logic              ferr_acc_q;
  logic              done_q;

  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              perr_q;
  logic              ferr_q;
  logic              overrun_q;

  logic baud_reload;
  logic tick;
  logic bit_sample;
  logic par_expect;

  assign baud_reload = (state_q == IDLE) && start_edge;
  // Mid-bit sample point for data, parity and stop bits
  assign bit_sample  = tick && (tick_cnt_q == FULL_TICK);
  assign par_expect  = par_q ^ (par_mode_q == ODD);

  uart_baud_tick u_baud (
    .clk      (clk),
    .rst_i    (rst_i),
    .div_i    (div_q),
    .reload_i (baud_reload),
    .tick_o   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q    <= IDLE;
      div_q      <= '0;
      par_mode_q <= NONE;
      stop2_q    <= 1'b0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (valid_q && rx_ready_i) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start_edge) begin
            div_q      <= clk_div_i;
            par_mode_q <= decode_parity(parity_mode_i);
            stop2_q    <= stop2_i;
            tick_cnt_q <= '0;
            state_q    <= START;
          end
        end

        START: begin
          if (tick) begin
            if (tick_cnt_q == HALF_TICK) begin
              tick_cnt_q <= '0;
              if (!rx_s) begin
                bit_cnt_q <= '0;
                par_q     <= 1'b0;
                state_q   <= DATA;
              end else begin
                // Line went back high: glitch, not a start bit
                state_q <= IDLE;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TW'(1);
            end
          end
        end

        DATA: begin
          if (tick) begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
            if (bit_sample) begin
              shift_q <= {rx_s, shift_q[DATA_W-1:1]};
              par_q   <= par_q ^ rx_s;
              if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_q  <= '0;
                perr_acc_q <= 1'b0;
                ferr_acc_q <= 1'b0;
                state_q    <= (par_mode_q != NONE) ? PARITY : STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + BW'(1);
              end
            end
          end
        end

        PARITY: begin
          if (tick) begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
            if (bit_sample) begin
              perr_acc_q <= (rx_s != par_expect);
              state_q    <= STOP;
            end
          end
        end

        STOP: begin
          if (done_q) begin
            // Completion cycle: deliver or drop the word
            done_q <= 1'b0;
            if (!valid_q || rx_ready_i) begin
              data_q  <= shift_q;
              perr_q  <= perr_acc_q;
              ferr_q  <= ferr_acc_q;
              valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
            state_q <= (ferr_acc_q && !rx_s) ? BREAK : IDLE;
          end else if (tick) begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
            if (bit_sample) begin
              if (!rx_s) begin
                ferr_acc_q <= 1'b1;
              end
              if (bit_cnt_q == BW'(stop2_q)) begin
                done_q <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + BW'(1);
              end
            end
          end
        end

        BREAK: begin
          if (rx_s) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data_o    = data_q;
  assign rx_valid_o   = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - scoreboard bench for uart_rx_cfg
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] clk_div_i;
  logic [1:0]  parity_mode_i;
  logic        stop2_i;
  logic        rx_i;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        parity_err_o;
  logic        frame_err_o;
  logic        overrun_o;

  always #5 clk = ~clk;

  uart_rx_cfg #(.DATA_W(8), .OS(OS)) dut (
    .clk           (clk),
    .rst_i         (rst_i),
    .clk_div_i     (clk_div_i),
    .parity_mode_i (parity_mode_i),
    .stop2_i       (stop2_i),
    .rx_i          (rx_i),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .rx_ready_i    (rx_ready_i),
    .parity_err_o  (parity_err_o),
    .frame_err_o   (frame_err_o),
    .overrun_o     (overrun_o)
  );

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   ovr_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every accepted word
  always @(negedge clk) begin
    if (overrun_o) ovr_cnt++;
    if (rx_valid_o && rx_ready_i) begin
      check("sb_nonempty", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rx_data", {24'd0, rx_data_o}, {24'd0, e.d});
        check("parity_err", {31'd0, parity_err_o}, {31'd0, e.pe});
        check("frame_err", {31'd0, frame_err_o}, {31'd0, e.fe});
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic b, input int nbits);
    rx_i = b;
    wait_cyc(nbits * OS);
  endtask

  // Sends one well-stopped frame using the current parity/stop config
  task automatic send_frame(input logic [7:0] d, input logic pbit, input bit push);
    exp_t x;
    x.d  = d;
    x.fe = 1'b0;
    case (parity_mode_i)
      2'b01:   x.pe = (pbit != ^d);
      2'b10:   x.pe = (pbit != ~^d);
      default: x.pe = 1'b0;
    endcase
    if (push) sb.push_back(x);
    send_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) send_bits(d[i], 1);
    if (parity_mode_i == 2'b01 || parity_mode_i == 2'b10) send_bits(pbit, 1);
    send_bits(1'b1, stop2_i ? 2 : 1);
    send_bits(1'b1, 1);
  endtask

  // Waits for the final stop sample; returns 1 if seen within budget
  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (dut.state_q == STOP && dut.done_q) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst_i = 1'b1;
    clk_div_i = 16'd0;
    parity_mode_i = 2'b00;
    stop2_i = 1'b0;
    rx_i = 1'b1;
    rx_ready_i = 1'b1;
    wait_cyc(3);
    check("rst_valid", {31'd0, rx_valid_o}, 32'd0);
    check("rst_data", {24'd0, rx_data_o}, 32'd0);
    check("rst_state", {29'd0, dut.state_q}, {29'd0, IDLE});
    rst_i = 1'b0;
    wait_cyc(5);

    // Even parity 0xA5, valid one cycle after the stop sample
    parity_mode_i = 2'b01;
    fork
      send_frame(8'hA5, 1'b0, 1'b1);
      begin
        wait_done(seen);
        check("a5_done_seen", {31'd0, seen}, 32'd1);
        check("a5_valid_before", {31'd0, rx_valid_o}, 32'd0);
        wait_cyc(1);
        check("a5_valid_after", {31'd0, rx_valid_o}, 32'd1);
      end
    join

    // Odd parity with wrong parity bit
    parity_mode_i = 2'b10;
    send_frame(8'h3C, 1'b0, 1'b1);
    // Mode 11 behaves as no parity
    parity_mode_i = 2'b11;
    send_frame(8'hC3, 1'b1, 1'b1);
    parity_mode_i = 2'b00;
    send_frame(8'h81, 1'b0, 1'b1);

    // Short glitch: no frame
    rx_i = 1'b0;
    wait_cyc(4);
    rx_i = 1'b1;
    wait_cyc(30);
    check("glitch_state", {29'd0, dut.state_q}, {29'd0, IDLE});
    check("glitch_valid", {31'd0, rx_valid_o}, 32'd0);

    // Two stop bits, second low, then a break
    stop2_i = 1'b1;
    e.d = 8'h0F; e.pe = 1'b0; e.fe = 1'b1;
    sb.push_back(e);
    send_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) send_bits(e.d[i], 1);
    send_bits(1'b1, 1);
    send_bits(1'b0, 3);
    check("break_state", {29'd0, dut.state_q}, {29'd0, BREAK});
    send_bits(1'b1, 2);
    check("break_exit", {29'd0, dut.state_q}, {29'd0, IDLE});
    send_frame(8'h55, 1'b0, 1'b1);
    stop2_i = 1'b0;

    // Overrun: 0x11 held, 0x22 dropped
    rx_ready_i = 1'b0;
    ovr_cnt = 0;
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0);
    check("ovr_data_held", {24'd0, rx_data_o}, 32'h11);
    check("ovr_valid_held", {31'd0, rx_valid_o}, 32'd1);
    check("ovr_pulses", ovr_cnt, 32'd1);

    // Accept coincides with completion: new word loads, no overrun
    ovr_cnt = 0;
    fork
      send_frame(8'h22, 1'b0, 1'b1);
      begin
        wait_done(seen);
        check("hs_done_seen", {31'd0, seen}, 32'd1);
        rx_ready_i = 1'b1;
      end
    join
    wait_cyc(5);
    check("hs_no_ovr", ovr_cnt, 32'd0);

    // Reset in data bit 4 with a held word present
    rx_ready_i = 1'b0;
    send_frame(8'h77, 1'b0, 1'b0);
    check("pre_rst_valid", {31'd0, rx_valid_o}, 32'd1);
    send_bits(1'b0, 1);
    for (int i = 0; i < 4; i++) send_bits(1'b1, 1);
    rx_i = 1'b0;
    wait_cyc(8);
    check("mid_state", {29'd0, dut.state_q}, {29'd0, DATA});
    rst_i = 1'b1;
    rx_i = 1'b1;
    wait_cyc(1);
    check("mrst_valid", {31'd0, rx_valid_o}, 32'd0);
    check("mrst_data", {24'd0, rx_data_o}, 32'd0);
    check("mrst_perr", {31'd0, parity_err_o}, 32'd0);
    check("mrst_ferr", {31'd0, frame_err_o}, 32'd0);
    check("mrst_ovr", {31'd0, overrun_o}, 32'd0);
    rst_i = 1'b0;
    rx_ready_i = 1'b1;
    wait_cyc(4 * OS);
    check("post_rst_valid", {31'd0, rx_valid_o}, 32'd0);
    send_frame(8'h9E, 1'b0, 1'b1);

    for (int i = 0; i < 200 && sb.size() != 0; i++) wait_cyc(1);
    check("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
